// File: rtl/ahb_dma_xfer_engine_pkg.sv
// Shared definitions for the AHB DMA transfer engine.
// Contents: the sequencer state enum, the AHB HSIZE/HBURST/HTRANS codes, and
// size_mask(), which gives the data mask for one element of a given HSIZE.
package ahb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_ERROR   = 3'd5
    } dma_xfer_state_t;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Elements are right-aligned on the data bus, so the mask keeps only
    // the low byte, the low halfword or the full word.
    function automatic logic [31:0] size_mask(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 32'h0000_00FF;
            HSIZE_HALF: return 32'h0000_FFFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ahb_dma_xfer_engine_if.sv
// Request/response bundle between the DMA transfer engine and the AHB DMA
// master interface.
//   transfer_size  HSIZE of the current beat
//   address        beat address
//   write_enable   1 = write beat
//   write_data     right-aligned write element
//   no_transfer    1 = IDLE on the bus
//   burst          HBURST, always SINGLE
//   burst_seq      sequential-burst flag, always 0
//   read_data      right-aligned read element
//   slave_wait     !HREADY: hold the current phase
//   error          registered HRESP error
// Modport master is the engine side; modport slave is the bus-interface side.
interface ahb_dma_xfer_engine_if #(
    parameter int ADDR_W = 32
);
    logic [2:0]        transfer_size;
    logic [ADDR_W-1:0] address;
    logic              write_enable;
    logic [31:0]       write_data;
    logic              no_transfer;
    logic [2:0]        burst;
    logic              burst_seq;
    logic [31:0]       read_data;
    logic              slave_wait;
    logic              error;

    modport master (
        output transfer_size, address, write_enable, write_data,
               no_transfer, burst, burst_seq,
        input  read_data, slave_wait, error
    );

    modport slave (
        input  transfer_size, address, write_enable, write_data,
               no_transfer, burst, burst_seq,
        output read_data, slave_wait, error
    );
endinterface

// File: rtl/ahb_dma_xfer_engine_addr_gen.sv
// Address pointer for one side (source or destination) of a DMA transfer.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   load          take start_addr as the new pointer
//   start_addr    first element address
//   advance       one element has been fully transferred
//   inc           1 = step the pointer after each element, 0 = fixed
//   size          HSIZE of the element; the step is 1 << size bytes
//   addr          current pointer (wraps modulo 2^ADDR_W)
module ahb_dma_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              advance,
    input  logic              inc,
    input  logic [2:0]        size,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] step;

    always_comb begin
        step = ADDR_W'(1) << size;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr <= '0;
        end else if (load) begin
            addr <= start_addr;
        end else if (advance && inc) begin
            addr <= addr + step;
        end
    end
endmodule

// File: rtl/ahb_dma_xfer_engine.sv
// Single-channel DMA transfer sequencer. Each element is one AHB read beat
// followed by one AHB write beat; the read element is held in data_q until it
// has been written out.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   cfg_start_i         one-cycle start pulse (ignored while busy)
//   cfg_abort_i         abort request, honoured only at a read address phase
//   cfg_src_addr_i      source start address
//   cfg_dst_addr_i      destination start address
//   cfg_size_i          element HSIZE (0 byte, 1 half, 2 word)
//   cfg_count_i         number of elements
//   cfg_src_inc_i       increment source pointer per element
//   cfg_dst_inc_i       increment destination pointer per element
//   bus                 request/response bundle to the AHB DMA master interface
//   busy_o              transfer in progress
//   done_o              one-cycle pulse on normal completion
//   err_o               sticky bus-error flag
//   aborted_o           sticky abort flag
//   cfg_err_o           one-cycle pulse when a start is rejected (size > 2)
//   remaining_o         elements not yet written
module ahb_dma_xfer_engine
    import ahb_dma_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_start_i,
    input  logic                  cfg_abort_i,
    input  logic [ADDR_W-1:0]     cfg_src_addr_i,
    input  logic [ADDR_W-1:0]     cfg_dst_addr_i,
    input  logic [2:0]            cfg_size_i,
    input  logic [CNT_W-1:0]      cfg_count_i,
    input  logic                  cfg_src_inc_i,
    input  logic                  cfg_dst_inc_i,
    ahb_dma_xfer_engine_if.master bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  aborted_o,
    output logic                  cfg_err_o,
    output logic [CNT_W-1:0]      remaining_o
);
    dma_xfer_state_t   state, state_nxt;

    logic [2:0]        size_q;
    logic              src_inc_q, dst_inc_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [31:0]       data_q;
    logic              done_q, cfg_err_q, err_q, aborted_q;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;

    logic start_req, size_ok, start_ok, xfer_load;
    logic bus_err, rd_done, beat_done, last_beat;

    always_comb begin
        start_req = (state == ST_IDLE) && cfg_start_i;
        size_ok   = (cfg_size_i <= HSIZE_WORD);
        start_ok  = start_req && size_ok;
        xfer_load = start_ok && (cfg_count_i != '0);
        bus_err   = (state != ST_IDLE) && bus.error;
        // A beat completes only when the slave is ready and no error is
        // reported in the same cycle; the error takes precedence.
        rd_done   = (state == ST_RD_DATA) && !bus.slave_wait && !bus.error;
        beat_done = (state == ST_WR_DATA) && !bus.slave_wait && !bus.error;
        last_beat = (remaining_q == CNT_W'(1));
    end

    ahb_dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (xfer_load),
        .start_addr (cfg_src_addr_i),
        .advance    (beat_done),
        .inc        (src_inc_q),
        .size       (size_q),
        .addr       (src_ptr)
    );

    ahb_dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (xfer_load),
        .start_addr (cfg_dst_addr_i),
        .advance    (beat_done),
        .inc        (dst_inc_q),
        .size       (size_q),
        .addr       (dst_ptr)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (xfer_load) state_nxt = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                if (bus.error)             state_nxt = ST_ERROR;
                else if (cfg_abort_i)      state_nxt = ST_IDLE;
                else if (!bus.slave_wait)  state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (bus.error)             state_nxt = ST_ERROR;
                else if (!bus.slave_wait)  state_nxt = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                if (bus.error)             state_nxt = ST_ERROR;
                else if (!bus.slave_wait)  state_nxt = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (bus.error)             state_nxt = ST_ERROR;
                else if (!bus.slave_wait)  state_nxt = last_beat ? ST_IDLE : ST_RD_ADDR;
            end
            ST_ERROR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus request outputs, decoded from the current state so that a wait
    // cycle (state held) keeps every request signal unchanged.
    always_comb begin
        bus.no_transfer  = 1'b1;
        bus.write_enable = 1'b0;
        bus.address      = '0;
        case (state)
            ST_RD_ADDR: begin
                bus.no_transfer = 1'b0;
                bus.address     = src_ptr;
            end
            ST_RD_DATA: begin
                bus.address     = src_ptr;
            end
            ST_WR_ADDR: begin
                bus.no_transfer  = 1'b0;
                bus.write_enable = 1'b1;
                bus.address      = dst_ptr;
            end
            ST_WR_DATA: begin
                bus.address     = dst_ptr;
            end
            default: begin
            end
        endcase
    end

    assign bus.burst         = HBURST_SINGLE;
    assign bus.burst_seq     = 1'b0;
    assign bus.write_data    = data_q;
    assign bus.transfer_size = busy_o ? size_q : 3'd0;

    // Configuration latch, element counter, data buffer and status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            size_q      <= '0;
            src_inc_q   <= 1'b0;
            dst_inc_q   <= 1'b0;
            remaining_q <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= (start_ok && (cfg_count_i == '0)) || (beat_done && last_beat);
            cfg_err_q <= start_req && !size_ok;

            if (xfer_load) begin
                size_q      <= cfg_size_i;
                src_inc_q   <= cfg_src_inc_i;
                dst_inc_q   <= cfg_dst_inc_i;
                remaining_q <= cfg_count_i;
            end

            if (start_ok) begin
                err_q     <= 1'b0;
                aborted_q <= 1'b0;
            end
            // bus_err is never true in IDLE, so it cannot collide with a start.
            if (bus_err) begin
                err_q <= 1'b1;
            end
            if ((state == ST_RD_ADDR) && cfg_abort_i && !bus.error) begin
                aborted_q <= 1'b1;
            end

            if (rd_done) begin
                data_q <= bus.read_data & size_mask(size_q);
            end
            if (beat_done) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

    assign busy_o      = (state != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign aborted_o   = aborted_q;
    assign cfg_err_o   = cfg_err_q;
    assign remaining_o = remaining_q;

endmodule

// File: tb/tb_ahb_dma_xfer_engine.sv
// Bench for ahb_dma_xfer_engine: a table of complete transfers with
// hand-computed results, followed by hand-written multi-cycle sequences for
// reset, rejected/empty starts, bus error, abort and reset mid-transfer.
module tb_ahb_dma_xfer_engine;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic        cfg_abort;
    logic [31:0] cfg_src;
    logic [31:0] cfg_dst;
    logic [2:0]  cfg_size;
    logic [15:0] cfg_count;
    logic        cfg_src_inc;
    logic        cfg_dst_inc;
    logic        busy, done, err, aborted, cfg_err;
    logic [15:0] remaining;

    int total = 0;
    int bad   = 0;

    ahb_dma_xfer_engine_if bus_if ();

    ahb_dma_xfer_engine #(.CNT_W(16), .ADDR_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_start_i    (cfg_start),
        .cfg_abort_i    (cfg_abort),
        .cfg_src_addr_i (cfg_src),
        .cfg_dst_addr_i (cfg_dst),
        .cfg_size_i     (cfg_size),
        .cfg_count_i    (cfg_count),
        .cfg_src_inc_i  (cfg_src_inc),
        .cfg_dst_inc_i  (cfg_dst_inc),
        .bus            (bus_if),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .aborted_o      (aborted),
        .cfg_err_o      (cfg_err),
        .remaining_o    (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  size;
        int          count;
        logic [31:0] src;
        logic [31:0] dst;
        logic        src_inc;
        logic        dst_inc;
        logic [31:0] rdata;
        logic        waits;      // one wait cycle on every data phase
        int          exp_done;   // cycle of done_o, start cycle = 0
        logic [31:0] exp_wdata;
        logic [31:0] exp_last_src;
        logic [31:0] exp_last_dst;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a start pulse in the current cycle (cycle 0) and returns
    // 1 time unit into cycle 1.
    task automatic start_xfer(input logic [2:0] size, input logic [15:0] count,
                              input logic [31:0] src, input logic [31:0] dst,
                              input logic si, input logic di);
        cfg_size    = size;
        cfg_count   = count;
        cfg_src     = src;
        cfg_dst     = dst;
        cfg_src_inc = si;
        cfg_dst_inc = di;
        cfg_start   = 1'b1;
        step();
        cfg_start   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] step_s, step_d, last_src, last_dst;
        logic [31:0] snap_addr, snap_wd;
        logic        snap_nt, snap_we, prev_wait, pend;
        int          rd_i, wr_i, done_cyc;
        step_s   = v.src_inc ? (32'd1 << v.size) : 32'd0;
        step_d   = v.dst_inc ? (32'd1 << v.size) : 32'd0;
        last_src = 32'hDEAD_BEEF;
        last_dst = 32'hDEAD_BEEF;
        snap_addr = '0; snap_wd = '0; snap_nt = 1'b0; snap_we = 1'b0;
        prev_wait = 1'b0;
        rd_i = 0; wr_i = 0; done_cyc = -1;
        bus_if.read_data  = v.rdata;
        bus_if.slave_wait = 1'b0;
        start_xfer(v.size, 16'(v.count), v.src, v.dst, v.src_inc, v.dst_inc);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (prev_wait) begin
                chk($sformatf("v%0d hold_addr", idx), bus_if.address, snap_addr);
                chk($sformatf("v%0d hold_nt", idx), 32'(bus_if.no_transfer), 32'(snap_nt));
                chk($sformatf("v%0d hold_we", idx), 32'(bus_if.write_enable), 32'(snap_we));
                chk($sformatf("v%0d hold_wdata", idx), bus_if.write_data, snap_wd);
            end
            prev_wait = bus_if.slave_wait;
            snap_addr = bus_if.address;
            snap_wd   = bus_if.write_data;
            snap_nt   = bus_if.no_transfer;
            snap_we   = bus_if.write_enable;
            if (!bus_if.no_transfer) begin
                chk($sformatf("v%0d hsize", idx), 32'(bus_if.transfer_size), 32'(v.size));
                if (!bus_if.write_enable) begin
                    chk($sformatf("v%0d rd_addr%0d", idx, rd_i), bus_if.address,
                        v.src + 32'(rd_i) * step_s);
                    last_src = bus_if.address;
                    rd_i++;
                end else begin
                    chk($sformatf("v%0d wr_addr%0d", idx, wr_i), bus_if.address,
                        v.dst + 32'(wr_i) * step_d);
                    chk($sformatf("v%0d wdata%0d", idx, wr_i), bus_if.write_data, v.exp_wdata);
                    last_dst = bus_if.address;
                    wr_i++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            pend = v.waits && !bus_if.no_transfer;
            step();
            bus_if.slave_wait = pend;
        end
        bus_if.slave_wait = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(v.exp_done));
        chk($sformatf("v%0d reads", idx), 32'(rd_i), 32'(v.count));
        chk($sformatf("v%0d writes", idx), 32'(wr_i), 32'(v.count));
        chk($sformatf("v%0d last_src", idx), last_src, v.exp_last_src);
        chk($sformatf("v%0d last_dst", idx), last_dst, v.exp_last_dst);
        chk($sformatf("v%0d remaining", idx), 32'(remaining), 32'd0);
        chk($sformatf("v%0d busy_at_done", idx), 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_end", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d hsize_idle", idx), 32'(bus_if.transfer_size), 32'd0);
        step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"},      32'(busy), 32'd0);
        chk({tag, " done"},      32'(done), 32'd0);
        chk({tag, " err"},       32'(err), 32'd0);
        chk({tag, " aborted"},   32'(aborted), 32'd0);
        chk({tag, " cfg_err"},   32'(cfg_err), 32'd0);
        chk({tag, " remaining"}, 32'(remaining), 32'd0);
        chk({tag, " nt"},        32'(bus_if.no_transfer), 32'd1);
        chk({tag, " we"},        32'(bus_if.write_enable), 32'd0);
        chk({tag, " addr"},      bus_if.address, 32'd0);
        chk({tag, " wdata"},     bus_if.write_data, 32'd0);
        chk({tag, " hsize"},     32'(bus_if.transfer_size), 32'd0);
        chk({tag, " burst"},     32'({bus_if.burst, bus_if.burst_seq}), 32'd0);
    endtask

    initial begin
        // size, count, src, dst, src_inc, dst_inc, rdata, waits, done, wdata, last_src, last_dst
        vecs[0] = '{3'd2, 4, 32'h2000_0000, 32'h2000_0100, 1'b1, 1'b1, 32'h1234_5678, 1'b0,
                    17, 32'h1234_5678, 32'h2000_000C, 32'h2000_010C};
        vecs[1] = '{3'd0, 3, 32'h3000_0000, 32'h4000_0010, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0,
                    13, 32'h0000_00DD, 32'h3000_0002, 32'h4000_0010};
        vecs[2] = '{3'd1, 2, 32'h5000_0002, 32'h6000_0000, 1'b1, 1'b1, 32'hAABB_CCDD, 1'b1,
                    13, 32'h0000_CCDD, 32'h5000_0004, 32'h6000_0002};
        vecs[3] = '{3'd2, 2, 32'hFFFF_FFFC, 32'h7000_0001, 1'b1, 1'b1, 32'h8765_4321, 1'b0,
                    9, 32'h8765_4321, 32'h0000_0000, 32'h7000_0005};
        vecs[4] = '{3'd1, 1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0001_FFFF, 1'b0,
                    5, 32'h0000_FFFF, 32'h0000_0010, 32'h0000_0020};

        rst = 1'b1;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_src = '0; cfg_dst = '0; cfg_size = '0; cfg_count = '0;
        cfg_src_inc = 1'b0; cfg_dst_inc = 1'b0;
        bus_if.read_data = '0; bus_if.slave_wait = 1'b0; bus_if.error = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Rejected start: size 3
        start_xfer(3'd3, 16'd2, 32'h100, 32'h200, 1'b1, 1'b1);
        @(negedge clk);
        chk("size3 cfg_err", 32'(cfg_err), 32'd1);
        chk("size3 busy", 32'(busy), 32'd0);
        chk("size3 nt", 32'(bus_if.no_transfer), 32'd1);
        step();
        @(negedge clk);
        chk("size3 cfg_err_end", 32'(cfg_err), 32'd0);
        chk("size3 busy2", 32'(busy), 32'd0);
        step();

        // Bus error in the second element's write data phase (cycle 8)
        bus_if.read_data = 32'h0BAD_F00D;
        start_xfer(3'd2, 16'd4, 32'h2000_0000, 32'h2000_0100, 1'b1, 1'b1);
        repeat (7) step();
        bus_if.error = 1'b1;
        @(negedge clk);
        chk("err wr_data nt", 32'(bus_if.no_transfer), 32'd1);
        chk("err wr_data addr", bus_if.address, 32'h2000_0104);
        chk("err wr_data remaining", 32'(remaining), 32'd3);
        step();
        bus_if.error = 1'b0;
        @(negedge clk);
        chk("err state busy", 32'(busy), 32'd1);
        chk("err state err", 32'(err), 32'd1);
        chk("err state nt", 32'(bus_if.no_transfer), 32'd1);
        chk("err state done", 32'(done), 32'd0);
        chk("err state remaining", 32'(remaining), 32'd3);
        step();
        @(negedge clk);
        chk("err idle busy", 32'(busy), 32'd0);
        chk("err idle done", 32'(done), 32'd0);
        chk("err idle err", 32'(err), 32'd1);
        chk("err idle remaining", 32'(remaining), 32'd3);
        step();

        // Empty start: done next cycle, clears the sticky error
        start_xfer(3'd2, 16'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("count0 done", 32'(done), 32'd1);
        chk("count0 busy", 32'(busy), 32'd0);
        chk("count0 err_cleared", 32'(err), 32'd0);
        chk("count0 nt", 32'(bus_if.no_transfer), 32'd1);
        step();

        // Abort held from the second element's read address phase (cycle 5)
        start_xfer(3'd2, 16'd4, 32'h2000_0000, 32'h2000_0100, 1'b1, 1'b1);
        repeat (4) step();
        cfg_abort = 1'b1;
        @(negedge clk);
        chk("abort rd_addr nt", 32'(bus_if.no_transfer), 32'd0);
        chk("abort rd_addr addr", bus_if.address, 32'h2000_0004);
        step();
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort flag", 32'(aborted), 32'd1);
        chk("abort remaining", 32'(remaining), 32'd3);
        chk("abort nt", 32'(bus_if.no_transfer), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        cfg_abort = 1'b0;
        step();

        // Abort together with slave_wait: abort wins
        start_xfer(3'd0, 16'd1, 32'h10, 32'h20, 1'b1, 1'b1);
        @(negedge clk);
        chk("abort_wait aborted_cleared", 32'(aborted), 32'd0);
        cfg_abort = 1'b1;
        bus_if.slave_wait = 1'b1;
        step();
        cfg_abort = 1'b0;
        bus_if.slave_wait = 1'b0;
        @(negedge clk);
        chk("abort_wait busy", 32'(busy), 32'd0);
        chk("abort_wait aborted", 32'(aborted), 32'd1);
        chk("abort_wait remaining", 32'(remaining), 32'd1);
        step();

        // Abort together with error: error wins
        start_xfer(3'd2, 16'd2, 32'h10, 32'h20, 1'b1, 1'b1);
        cfg_abort = 1'b1;
        bus_if.error = 1'b1;
        step();
        cfg_abort = 1'b0;
        bus_if.error = 1'b0;
        @(negedge clk);
        chk("abort_err busy", 32'(busy), 32'd1);
        chk("abort_err err", 32'(err), 32'd1);
        chk("abort_err aborted", 32'(aborted), 32'd0);
        step();
        @(negedge clk);
        chk("abort_err idle busy", 32'(busy), 32'd0);
        chk("abort_err idle aborted", 32'(aborted), 32'd0);
        step();

        // Reset in the write address phase (cycle 3)
        bus_if.read_data = 32'hCAFE_1234;
        start_xfer(3'd2, 16'd2, 32'h8000_0000, 32'h9000_0000, 1'b1, 1'b1);
        repeat (2) step();
        @(negedge clk);
        chk("rst_mid we", 32'(bus_if.write_enable), 32'd1);
        chk("rst_mid wdata", bus_if.write_data, 32'hCAFE_1234);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_reset_state("rst_mid");
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
